// File: rtl/nrst_pkg.sv
// Shared state encoding and default timing constants for the reset pulse generator.
package nrst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE
    } nrst_state_t;

    localparam int unsigned DEFAULT_HOLD_CYCLES     = 16;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1024;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes and debounces an asynchronous active-low button and emits a
// single-cycle press event on each debounced 1->0 transition.
module btn_debouncer import nrst_pkg::*; #(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK_I,
    input  logic NRST_I,
    input  logic BTN_N_I,
    output logic PRESS_O
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   btn_s;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], BTN_N_I};
        btn_s    = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = '0;
        // Any sample that agrees with the stable level restarts the qualification window.
        if (btn_s != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            sync_q   <= '1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign PRESS_O = press_q;

endmodule

// File: rtl/nrst_pulse_generator.sv
// Merges system reset, debounced button and software request into one registered
// active-low reset pulse of HOLD_CYCLES minimum width, with a release acknowledge.
module nrst_pulse_generator import nrst_pkg::*; #(
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic CLK_I,
    input  logic NRST_I,
    input  logic BTN_N_I,
    input  logic REQ_I,
    output logic NRST_O,
    output logic BUSY_O,
    output logic ACK_O
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

    nrst_state_t      state_q, state_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             nrst_q, nrst_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             press;
    logic             trigger;

    btn_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .CLK_I   (CLK_I),
        .NRST_I  (NRST_I),
        .BTN_N_I (BTN_N_I),
        .PRESS_O (press)
    );

    always_comb begin
        trigger    = REQ_I | press;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = ASSERT;
                    hold_cnt_d = '0;
                end
            end
            ASSERT: begin
                // A fresh trigger restarts the hold window, stretching the pulse.
                if (trigger) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
                    state_d    = RELEASE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            RELEASE: begin
                hold_cnt_d = '0;
                state_d    = trigger ? ASSERT : IDLE;
            end
            default: begin
                state_d    = ASSERT;
                hold_cnt_d = '0;
            end
        endcase
        // Outputs are decoded from the next state so they appear registered with the state.
        nrst_d = (state_d != ASSERT);
        busy_d = (state_d != IDLE);
        ack_d  = (state_d == RELEASE);
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            state_q    <= ASSERT;
            hold_cnt_q <= '0;
            nrst_q     <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            nrst_q     <= nrst_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign NRST_O = nrst_q;
    assign BUSY_O = busy_q;
    assign ACK_O  = ack_q;

endmodule

// File: tb/tb_nrst_pulse_generator.sv
// Self-checking bench for nrst_pulse_generator: vector table of software request
// scenarios plus hand-written reset and button sequences, scored against a pulse queue.
module tb_nrst_pulse_generator;

    localparam int unsigned HOLD = 16;
    localparam int unsigned DEB  = 8;
    localparam int unsigned SYNC = 2;
    localparam int          BTN_LAT = DEB + SYNC + 1;

    logic clk = 1'b0;
    logic nrst_i;
    logic btn_n;
    logic req;
    logic nrst_o;
    logic busy_o;
    logic ack_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor-owned records of what the DUT produced.
    int   got_q[$];
    int   fall_log[$];
    int   ack_seen = 0;
    int   low_len = 0;
    logic prev_nrst = 1'b1;

    // Bench-owned expected pulse lengths.
    int exp_q[$];

    typedef struct {
        string name;
        int    k;
        int    n_pulse;
        int    len0;
        int    len1;
        int    acks;
    } vec_t;

    vec_t vecs[6];

    nrst_pulse_generator #(
        .HOLD_CYCLES     (HOLD),
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .CLK_I   (clk),
        .NRST_I  (nrst_i),
        .BTN_N_I (btn_n),
        .REQ_I   (req),
        .NRST_O  (nrst_o),
        .BUSY_O  (busy_o),
        .ACK_O   (ack_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!nrst_o) begin
            if (prev_nrst) fall_log.push_back(cyc);
            low_len++;
        end else begin
            if (!prev_nrst) got_q.push_back(low_len);
            low_len = 0;
        end
        if (ack_o) ack_seen++;
        prev_nrst = nrst_o;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy_o && nrst_o) break;
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy=%0b nrst=%0b after 100 cycles, required idle",
                     name, busy_o, nrst_o);
        end
        tick();
    endtask

    // Counts edges from reset deassert until NRST_O rises, then checks the ACK/BUSY tail.
    task automatic measure_release(input string name);
        int n;
        int early;
        n = 0;
        early = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (nrst_o) break;
            if (ack_o) early++;
        end
        check({name, "_release_cycles"}, n, HOLD);
        check({name, "_early_ack"}, early, 0);
        check({name, "_ack_high"}, int'(ack_o), 1);
        check({name, "_busy_in_release"}, int'(busy_o), 1);
        tick();
        check({name, "_ack_low"}, int'(ack_o), 0);
        check({name, "_busy_low"}, int'(busy_o), 0);
        check({name, "_nrst_high"}, int'(nrst_o), 1);
    endtask

    task automatic score(input string name, input int got_base, input int fall_base,
                         input int t_fall, input int exp_acks, input int ack_base);
        int idx;
        int e;
        idx = got_base;
        check({name, "_first_fall"},
              (fall_log.size() > fall_base) ? fall_log[fall_base] : -1, t_fall);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_pulse_len"}, (idx < got_q.size()) ? got_q[idx] : -1, e);
            idx++;
        end
        check({name, "_extra_pulses"}, got_q.size() - idx, 0);
        check({name, "_acks"}, ack_seen - ack_base, exp_acks);
        check({name, "_idle_nrst"}, int'(nrst_o), 1);
    endtask

    initial begin
        int t0;
        int gb;
        int fb;
        int ab;

        // k = edge (after the first request) at which a second request is sampled.
        vecs[0] = '{"single",       0,  1, 16, 0,  1};
        vecs[1] = '{"retrig_cnt10", 11, 1, 27, 0,  1};
        vecs[2] = '{"retrig_cnt0",  1,  1, 17, 0,  1};
        vecs[3] = '{"retrig_last",  16, 1, 32, 0,  1};
        vecs[4] = '{"trig_release", 17, 2, 16, 16, 2};
        vecs[5] = '{"trig_idle",    18, 2, 16, 16, 2};

        nrst_i = 1'b0;
        btn_n  = 1'b1;
        req    = 1'b0;

        // Power-on reset.
        repeat (5) tick();
        check("rst_nrst", int'(nrst_o), 0);
        check("rst_busy", int'(busy_o), 1);
        check("rst_ack", int'(ack_o), 0);
        nrst_i = 1'b1;
        measure_release("por");
        repeat (3) tick();

        // Software request scenarios.
        foreach (vecs[i]) begin
            gb = got_q.size();
            fb = fall_log.size();
            ab = ack_seen;
            exp_q.push_back(vecs[i].len0);
            if (vecs[i].n_pulse == 2) exp_q.push_back(vecs[i].len1);
            t0 = cyc;
            req = 1'b1;
            tick();
            req = 1'b0;
            if (vecs[i].k > 0) begin
                repeat (vecs[i].k - 1) tick();
                req = 1'b1;
                tick();
                req = 1'b0;
            end
            wait_idle(vecs[i].name);
            score(vecs[i].name, gb, fb, t0 + 1, vecs[i].acks, ab);
            repeat (3) tick();
        end

        // Bouncy button, then held low well past the pulse.
        gb = got_q.size();
        fb = fall_log.size();
        ab = ack_seen;
        exp_q.push_back(HOLD);
        btn_n = 1'b0;
        repeat (3) tick();
        btn_n = 1'b1;
        repeat (2) tick();
        btn_n = 1'b0;
        t0 = cyc;
        repeat (43) tick();
        btn_n = 1'b1;
        repeat (30) tick();
        wait_idle("button");
        score("button", gb, fb, t0 + BTN_LAT, 1, ab);

        // Request coincident with the debounced press event.
        gb = got_q.size();
        fb = fall_log.size();
        ab = ack_seen;
        exp_q.push_back(HOLD);
        btn_n = 1'b0;
        t0 = cyc;
        repeat (BTN_LAT - 1) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (30) tick();
        btn_n = 1'b1;
        repeat (30) tick();
        wait_idle("coincident");
        score("coincident", gb, fb, t0 + BTN_LAT, 1, ab);

        // System reset asserted mid-pulse at hold_cnt == 7.
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (7) tick();
        nrst_i = 1'b0;
        #1;
        check("midrst_nrst", int'(nrst_o), 0);
        check("midrst_busy", int'(busy_o), 1);
        check("midrst_ack", int'(ack_o), 0);
        repeat (3) tick();
        nrst_i = 1'b1;
        measure_release("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
